// File: rtl/xfer_sequencer_if.sv
// Instruction handshake plus the select/enable bus between the sequencer and
// the source/destination 3x8 decoders.
interface xfer_sequencer_if;
  logic [7:0] instr;
  logic       instr_valid;
  logic       instr_ready;
  logic [2:0] src_sel;
  logic       src_en;
  logic [2:0] dst_sel;
  logic       dst_en;
  logic       alu_go;
  logic       halted;
  logic [7:0] retired;
  logic [7:0] imm_bus;

  modport master (
    output instr, instr_valid,
    input  instr_ready, src_sel, src_en, dst_sel, dst_en,
           alu_go, halted, retired, imm_bus
  );

  modport slave (
    input  instr, instr_valid,
    output instr_ready, src_sel, src_en, dst_sel, dst_en,
           alu_go, halted, retired, imm_bus
  );
endinterface

// File: rtl/xfer_sequencer.sv
// Byte-fed transfer sequencer driving the bus source and register load
// decoders; all outputs decode from registered state, ir and imm.
//
// state  | meaning
// IDLE   | ready for an instruction byte
// MOV    | drive src -> dst for one cycle
// LDI_W  | waiting for the immediate byte
// LDI_WR | drive immediate bus -> dst
// ALU1   | load src into ALU operand-A latch
// ALU2   | ALU result -> dst, alu_go asserted
// HALT   | stopped until reset
module xfer_sequencer #(
  parameter logic [2:0] IMM_SRC   = 3'd7,
  parameter logic [2:0] ALU_SRC   = 3'd6,
  parameter logic [2:0] ALU_A_DST = 3'd7
) (
  input  logic            clk,
  input  logic            rst,
  xfer_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_MOV    = 3'd1,
    S_LDI_W  = 3'd2,
    S_LDI_WR = 3'd3,
    S_ALU1   = 3'd4,
    S_ALU2   = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [5:0] ir;       // opcode is consumed at decode; only dst/src are kept
  logic [7:0] imm;
  logic [7:0] retired;
  logic       xfer;
  logic       retire;

  assign xfer   = bus.instr_valid & bus.instr_ready;
  assign retire = (state == S_MOV) | (state == S_LDI_WR) | (state == S_ALU2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (xfer) begin
          unique case (bus.instr[7:6])
            2'b00: state_nxt = S_MOV;
            2'b01: state_nxt = S_LDI_W;
            2'b10: state_nxt = S_ALU1;
            2'b11: state_nxt = S_HALT;
          endcase
        end
      end
      S_MOV:    state_nxt = S_IDLE;
      S_LDI_W:  if (xfer) state_nxt = S_LDI_WR;
      S_LDI_WR: state_nxt = S_IDLE;
      S_ALU1:   state_nxt = S_ALU2;
      S_ALU2:   state_nxt = S_IDLE;
      S_HALT:   state_nxt = S_HALT;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir      <= '0;
      imm     <= '0;
      retired <= '0;
    end else begin
      if (state == S_IDLE && xfer) ir <= bus.instr[5:0];
      // Immediate byte is data regardless of its top bits.
      if (state == S_LDI_W && xfer) imm <= bus.instr;
      if (retire) retired <= retired + 8'd1;
    end
  end

  always_comb begin
    bus.instr_ready = 1'b0;
    bus.src_sel     = 3'd0;
    bus.dst_sel     = 3'd0;
    bus.src_en      = 1'b0;
    bus.dst_en      = 1'b0;
    bus.alu_go      = 1'b0;
    bus.halted      = 1'b0;
    unique case (state)
      S_IDLE:  bus.instr_ready = 1'b1;
      S_MOV: begin
        bus.src_sel = ir[2:0];
        bus.dst_sel = ir[5:3];
        bus.src_en  = 1'b1;
        bus.dst_en  = 1'b1;
      end
      S_LDI_W: bus.instr_ready = 1'b1;
      S_LDI_WR: begin
        bus.src_sel = IMM_SRC;
        bus.dst_sel = ir[5:3];
        bus.src_en  = 1'b1;
        bus.dst_en  = 1'b1;
      end
      S_ALU1: begin
        bus.src_sel = ir[2:0];
        bus.dst_sel = ALU_A_DST;
        bus.src_en  = 1'b1;
        bus.dst_en  = 1'b1;
      end
      S_ALU2: begin
        bus.src_sel = ALU_SRC;
        bus.dst_sel = ir[5:3];
        bus.src_en  = 1'b1;
        bus.dst_en  = 1'b1;
        bus.alu_go  = 1'b1;
      end
      S_HALT:  bus.halted = 1'b1;
      default: bus.instr_ready = 1'b0;
    endcase
  end

  assign bus.retired = retired;
  assign bus.imm_bus = imm;

endmodule

// File: tb/tb_xfer_sequencer.sv
// Directed bench for xfer_sequencer: hand-computed expectations checked with
// immediate assertions, sampled 1 time unit after each rising edge.
module tb_xfer_sequencer;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   passed = 0;

  xfer_sequencer_if bus_if ();

  xfer_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Checks the full decoder drive in one go.
  task automatic chk_bus(input string tag, input logic [2:0] s, input logic [2:0] d,
                         input logic en, input logic go, input logic rdy);
    chk({tag, ".src_sel"}, {29'd0, bus_if.src_sel}, {29'd0, s});
    chk({tag, ".dst_sel"}, {29'd0, bus_if.dst_sel}, {29'd0, d});
    chk({tag, ".src_en"},  {31'd0, bus_if.src_en},  {31'd0, en});
    chk({tag, ".dst_en"},  {31'd0, bus_if.dst_en},  {31'd0, en});
    chk({tag, ".alu_go"},  {31'd0, bus_if.alu_go},  {31'd0, go});
    chk({tag, ".ready"},   {31'd0, bus_if.instr_ready}, {31'd0, rdy});
  endtask

  initial begin
    logic [7:0] ret_hold;
    rst = 1'b1;
    bus_if.instr = 8'h00;
    bus_if.instr_valid = 1'b0;
    step();
    step();
    chk_bus("reset", 3'd0, 3'd0, 1'b0, 1'b0, 1'b1);
    chk("reset.halted", {31'd0, bus_if.halted}, 32'd0);
    chk("reset.retired", {24'd0, bus_if.retired}, 32'd0);
    rst = 1'b0;

    // MOV r2 -> r3
    bus_if.instr = 8'b00_011_010;
    bus_if.instr_valid = 1'b1;
    step();
    bus_if.instr_valid = 1'b0;
    chk_bus("mov", 3'd2, 3'd3, 1'b1, 1'b0, 1'b0);
    step();
    chk_bus("mov.done", 3'd0, 3'd0, 1'b0, 1'b0, 1'b1);
    chk("mov.retired", {24'd0, bus_if.retired}, 32'd1);

    // LDI r5 with a 4-cycle wait for the immediate byte
    bus_if.instr = 8'b01_101_000;
    bus_if.instr_valid = 1'b1;
    step();
    bus_if.instr_valid = 1'b0;
    bus_if.instr = 8'hxx;
    chk_bus("ldi_w0", 3'd0, 3'd0, 1'b0, 1'b0, 1'b1);
    step();
    chk_bus("ldi_w1", 3'd0, 3'd0, 1'b0, 1'b0, 1'b1);
    step();
    chk_bus("ldi_w2", 3'd0, 3'd0, 1'b0, 1'b0, 1'b1);
    step();
    chk_bus("ldi_w3", 3'd0, 3'd0, 1'b0, 1'b0, 1'b1);
    bus_if.instr = 8'hC5;
    bus_if.instr_valid = 1'b1;
    step();
    bus_if.instr_valid = 1'b0;
    chk_bus("ldi_wr", 3'd7, 3'd5, 1'b1, 1'b0, 1'b0);
    chk("ldi_wr.imm", {24'd0, bus_if.imm_bus}, 32'hC5);
    step();
    chk("ldi.retired", {24'd0, bus_if.retired}, 32'd2);

    // ALU r4 -> r1
    bus_if.instr = 8'b10_001_100;
    bus_if.instr_valid = 1'b1;
    step();
    bus_if.instr_valid = 1'b0;
    chk_bus("alu1", 3'd4, 3'd7, 1'b1, 1'b0, 1'b0);
    step();
    chk_bus("alu2", 3'd6, 3'd1, 1'b1, 1'b1, 1'b0);
    step();
    chk_bus("alu.done", 3'd0, 3'd0, 1'b0, 1'b0, 1'b1);
    chk("alu.retired", {24'd0, bus_if.retired}, 32'd3);

    // LDI r2 with an immediate that looks like HLT, issued back-to-back
    bus_if.instr = 8'b01_010_000;
    bus_if.instr_valid = 1'b1;
    step();
    bus_if.instr = 8'hC0;
    chk("ldi2.ready", {31'd0, bus_if.instr_ready}, 32'd1);
    step();
    bus_if.instr_valid = 1'b0;
    chk_bus("ldi2_wr", 3'd7, 3'd2, 1'b1, 1'b0, 1'b0);
    chk("ldi2.imm", {24'd0, bus_if.imm_bus}, 32'hC0);
    chk("ldi2.halted", {31'd0, bus_if.halted}, 32'd0);
    step();
    chk("ldi2.retired", {24'd0, bus_if.retired}, 32'd4);

    // 256 back-to-back MOVs, src==dst included; counter wraps through 0
    for (int i = 0; i < 256; i++) begin
      bus_if.instr = {2'b00, i[5:0]};
      bus_if.instr_valid = 1'b1;
      step();
      chk("b2b.src_sel", {29'd0, bus_if.src_sel}, {29'd0, i[2:0]});
      chk("b2b.dst_sel", {29'd0, bus_if.dst_sel}, {29'd0, i[5:3]});
      chk("b2b.en_pair", {30'd0, bus_if.src_en, bus_if.dst_en}, 32'd3);
      step();
      chk("b2b.en_off", {30'd0, bus_if.src_en, bus_if.dst_en}, 32'd0);
      if (i == 251) chk("b2b.wrap", {24'd0, bus_if.retired}, 32'd0);
      if (i == 250) chk("b2b.max", {24'd0, bus_if.retired}, 32'd255);
    end
    bus_if.instr_valid = 1'b0;
    chk("b2b.retired", {24'd0, bus_if.retired}, 32'd4);

    // HLT, then further valid bytes are ignored
    bus_if.instr = 8'hC0;
    bus_if.instr_valid = 1'b1;
    step();
    chk("hlt.halted", {31'd0, bus_if.halted}, 32'd1);
    ret_hold = 8'd4;
    for (int i = 0; i < 4; i++) begin
      bus_if.instr = 8'b00_001_010;
      step();
      chk_bus("hlt.idle", 3'd0, 3'd0, 1'b0, 1'b0, 1'b0);
      chk("hlt.stay", {31'd0, bus_if.halted}, 32'd1);
      chk("hlt.retired", {24'd0, bus_if.retired}, {24'd0, ret_hold});
    end
    bus_if.instr_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("hlt.rst_halted", {31'd0, bus_if.halted}, 32'd0);
    chk("hlt.rst_ready", {31'd0, bus_if.instr_ready}, 32'd1);
    #2;
    rst = 1'b0;

    // Asynchronous reset mid-cycle during ALU2, ALU with dst == ALU_A_DST
    bus_if.instr = 8'b00_011_010;
    bus_if.instr_valid = 1'b1;
    step();
    bus_if.instr_valid = 1'b0;
    step();
    chk("pre.retired", {24'd0, bus_if.retired}, 32'd1);
    bus_if.instr = 8'b10_111_011;
    bus_if.instr_valid = 1'b1;
    step();
    bus_if.instr_valid = 1'b0;
    chk_bus("alu1b", 3'd3, 3'd7, 1'b1, 1'b0, 1'b0);
    step();
    chk_bus("alu2b", 3'd6, 3'd7, 1'b1, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk_bus("async_rst", 3'd0, 3'd0, 1'b0, 1'b0, 1'b1);
    chk("async_rst.retired", {24'd0, bus_if.retired}, 32'd0);
    step();
    rst = 1'b0;
    step();
    chk("post_rst.retired", {24'd0, bus_if.retired}, 32'd0);
    chk("post_rst.halted", {31'd0, bus_if.halted}, 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
